q_max_selector: RTL and testbench

Sequential Q-table reader that feeds the Q-value update datapath. For the current board it scans the nine action entries of one Q-table row, skips occupied cells, and returns the largest legal Q-value (`max_Q`) and its action index (`best_action`). It is the read side of the learning loop: `max_Q` drives the update's gamma·maxQ term, and `best_action` drives greedy move selection. Row selection (the state → row mapping) is done externally; this block supplies only the action address.

---
 rtl/q_max_selector.sv | 172 +++++++++++++++++
 tb/tb_q_max_selector.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/q_max_selector.sv
// Sequential Q-table row scanner: reads the nine action entries, skips occupied
// cells and reports the largest legal signed Q-value and its action index.
module q_max_selector #(
  parameter int QW    = 16,
  parameter int NCELL = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*NCELL-1:0]   board,
  output logic                 rd_en,
  output logic [3:0]           rd_addr,
  input  logic [QW-1:0]        rd_data,
  output logic                 busy,
  output logic                 done,
  output logic [QW-1:0]        max_Q,
  output logic [3:0]           best_action,
  output logic                 no_legal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_ACT = 4'(NCELL - 1);
  localparam logic [3:0] NO_ACT   = 4'hF;

  state_t               state_q, state_d;
  logic [2*NCELL-1:0]   board_q, board_d;
  logic                 rd_en_q, rd_en_d;
  logic [3:0]           rd_addr_q, rd_addr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pipe_en_q, pipe_en_d;
  logic [3:0]           pipe_addr_q, pipe_addr_d;
  logic [QW-1:0]        run_max_q, run_max_d;
  logic [3:0]           run_idx_q, run_idx_d;
  logic                 found_q, found_d;
  logic [QW-1:0]        max_q_q, max_q_d;
  logic [3:0]           best_action_q, best_action_d;
  logic                 no_legal_q, no_legal_d;

  logic [15:0]          empty_mask;
  logic [3:0]           next_addr;
  logic                 take;
  logic [QW-1:0]        cand_max;
  logic [3:0]           cand_idx;
  logic                 cand_found;

  always_comb begin
    empty_mask = '0;
    for (int unsigned i = 0; i < NCELL; i++) begin
      empty_mask[i] = (board_q[2*i +: 2] == 2'b00);
    end
  end

  assign next_addr = rd_addr_q + 4'd1;

  // Compare stage: the delayed strobe marks rd_data as the word for pipe_addr_q.
  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    take       = pipe_en_q && (!found_q || ($signed(rd_data) > $signed(run_max_q)));
    cand_max   = take ? rd_data : run_max_q;
    cand_idx   = take ? pipe_addr_q : run_idx_q;
    cand_found = found_q | pipe_en_q;
  end

  always_comb begin
    state_d       = state_q;
    board_d       = board_q;
    rd_en_d       = 1'b0;
    rd_addr_d     = rd_addr_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pipe_en_d     = rd_en_q;
    pipe_addr_d   = rd_addr_q;
    run_max_d     = cand_max;
    run_idx_d     = cand_idx;
    found_d       = cand_found;
    max_q_d       = max_q_q;
    best_action_d = best_action_q;
    no_legal_d    = no_legal_q;

    unique case (state_q)
      S_IDLE: begin
        rd_addr_d = '0;
        if (start) begin
          state_d   = S_ISSUE;
          board_d   = board;
          // First issue slot is registered on the accepting edge, so it
          // must look at the incoming board rather than the latched copy.
          rd_en_d   = (board[1:0] == 2'b00);
          busy_d    = 1'b1;
          found_d   = 1'b0;
          run_max_d = '0;
          run_idx_d = NO_ACT;
        end
      end
      S_ISSUE: begin
        if (rd_addr_q == LAST_ACT) begin
          state_d   = S_DRAIN;
          rd_addr_d = '0;
        end else begin
          rd_addr_d = next_addr;
          rd_en_d   = empty_mask[next_addr];
        end
      end
      S_DRAIN: begin
        // Final word is folded in here so results are valid in the done cycle.
        state_d       = S_DONE;
        done_d        = 1'b1;
        max_q_d       = cand_found ? cand_max : '0;
        best_action_d = cand_found ? cand_idx : NO_ACT;
        no_legal_d    = !cand_found;
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      board_q       <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pipe_en_q     <= 1'b0;
      pipe_addr_q   <= '0;
      run_max_q     <= '0;
      run_idx_q     <= NO_ACT;
      found_q       <= 1'b0;
      max_q_q       <= '0;
      best_action_q <= NO_ACT;
      no_legal_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      board_q       <= board_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pipe_en_q     <= pipe_en_d;
      pipe_addr_q   <= pipe_addr_d;
      run_max_q     <= run_max_d;
      run_idx_q     <= run_idx_d;
      found_q       <= found_d;
      max_q_q       <= max_q_d;
      best_action_q <= best_action_d;
      no_legal_q    <= no_legal_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign max_Q       = max_q_q;
  assign best_action = best_action_q;
  assign no_legal    = no_legal_q;

endmodule

// File: tb/tb_q_max_selector.sv
// Bench for q_max_selector: table of boards/Q-rows, a 1-cycle-latency memory
// model and a result scoreboard popped on every done pulse.
module tb_q_max_selector;

  localparam int QW    = 16;
  localparam int NCELL = 9;

  typedef struct packed {
    logic [17:0]  board;
    logic [143:0] q;
    logic [15:0]  exp_max;
    logic [3:0]   exp_best;
    logic         exp_nl;
    logic [8:0]   mask;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [17:0]       board;
  logic              rd_en;
  logic [3:0]        rd_addr;
  logic [QW-1:0]     rd_data;
  logic              busy;
  logic              done;
  logic [QW-1:0]     max_Q;
  logic [3:0]        best_action;
  logic              no_legal;

  logic [15:0]       q_mem [0:15];
  vec_t              sb [$];
  vec_t              vecs [0:7];
  vec_t              mon_e;
  int                n_vec = 0;
  int                n_err = 0;

  q_max_selector #(.QW(QW), .NCELL(NCELL)) dut (
    .clk(clk), .rst(rst), .start(start), .board(board),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .max_Q(max_Q),
    .best_action(best_action), .no_legal(no_legal)
  );

  always #5 clk = ~clk;

  // Memory model: word valid one cycle after the strobe; poison when not read.
  always @(posedge clk) begin
    if (rd_en) rd_data <= q_mem[rd_addr];
    else       rd_data <= 16'h7FFF;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [143:0] qpack(input int a0, input int a1, input int a2,
                                         input int a3, input int a4, input int a5,
                                         input int a6, input int a7, input int a8);
    return {16'(a8), 16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  function automatic vec_t mkv(input logic [17:0] b, input logic [143:0] q, input int mx,
                               input logic [3:0] best, input logic nl, input logic [8:0] m);
    vec_t v;
    v.board = b; v.q = q; v.exp_max = 16'(mx); v.exp_best = best; v.exp_nl = nl; v.mask = m;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending scan (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("max_Q", 32'(max_Q), 32'(mon_e.exp_max));
        chk("best_action", 32'(best_action), 32'(mon_e.exp_best));
        chk("no_legal", 32'(no_legal), 32'(mon_e.exp_nl));
      end
    end
  end

  task automatic load(input vec_t v);
    board = v.board;
    for (int i = 0; i < NCELL; i++) q_mem[i] = v.q[16*i +: 16];
  endtask

  task automatic do_scan(input vec_t v, input bit disturb);
    int done_at = -1;
    @(negedge clk);
    load(v);
    start = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge clk);
      if (j < 9) begin
        chk("rd_addr", 32'(rd_addr), 32'(j));
        chk("rd_en", 32'(rd_en), 32'(v.mask[j]));
      end
      if (j <= 10) chk("busy", 32'(busy), 32'd1);
      if (disturb && j == 3) begin start = 1'b1; board = 18'h15555; end
      if (disturb && j == 5) start = 1'b0;
      if (done) begin done_at = j; break; end
    end
    chk("latency", 32'(done_at), 32'd10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int first_done;
    int second_done;
    for (int i = 0; i < 16; i++) q_mem[i] = '0;
    rst = 1'b1; start = 1'b0; board = '0;

    vecs[0] = mkv(18'h00000, qpack(5, 12, -3, 12, 7, 0, 1, 2, -8), 12, 4'd1, 1'b0, 9'h1FF);
    vecs[1] = mkv(18'h00084, qpack(5, 12, -3, 12, 7, 0, 1, 2, -8), 7, 4'd4, 1'b0, 9'h1F5);
    vecs[2] = mkv(18'h15555, qpack(5, 12, -3, 12, 7, 0, 1, 2, -8), 0, 4'hF, 1'b1, 9'h000);
    vecs[3] = mkv(18'h00FFF, qpack(100, 100, 100, 100, 100, 100, -20, -4, -4), -4, 4'd7, 1'b0, 9'h1C0);
    vecs[4] = mkv(18'h0AAAA, qpack(50, 50, 50, 50, 50, 50, 50, 50, -32768), -32768, 4'd8, 1'b0, 9'h100);
    vecs[5] = mkv(18'h15554, qpack(3, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000), 3, 4'd0, 1'b0, 9'h001);
    vecs[6] = mkv(18'h00000, qpack(9, 9, 9, 9, 9, 9, 9, 9, 9), 9, 4'd0, 1'b0, 9'h1FF);
    vecs[7] = mkv(18'h00000, qpack(0, 1, 2, 3, 4, 5, 6, 7, 8), 8, 4'd8, 1'b0, 9'h1FF);

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_max_Q", 32'(max_Q), 32'd0);
    chk("rst_best", 32'(best_action), 32'hF);
    chk("rst_no_legal", 32'(no_legal), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) do_scan(vecs[k], 1'b0);

    // Reset in the middle of a scan (action 4 issuing).
    @(negedge clk);
    load(vecs[0]);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_addr", 32'(rd_addr), 32'd4);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd_en", 32'(rd_en), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_max_Q", 32'(max_Q), 32'd0);
    chk("midrst_best", 32'(best_action), 32'hF);
    chk("midrst_no_legal", 32'(no_legal), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("no_done_after_rst", 32'(seen), 32'd0);
    chk("post_rst_best", 32'(best_action), 32'hF);
    do_scan(vecs[1], 1'b0);

    // Start pulse and board change mid-scan must be ignored.
    do_scan(vecs[0], 1'b1);

    // Start held high: second done exactly 12 cycles after the first.
    @(negedge clk);
    load(vecs[3]);
    start = 1'b1;
    sb.push_back(vecs[3]);
    sb.push_back(vecs[3]);
    first_done = -1;
    second_done = -1;
    @(posedge clk);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done) begin
        if (first_done < 0) first_done = j;
        else begin second_done = j; start = 1'b0; break; end
      end
    end
    start = 1'b0;
    chk("hold_first_done", 32'(first_done), 32'd10);
    chk("hold_second_done", 32'(second_done), 32'd22);

    repeat (20) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
